// File: rtl/sorcerer_kbd_matrix.sv
// ---------------------------------------------------------------------------
// sorcerer_kbd_matrix
//
// Turns hps_io ps2_key events into the Sorcerer's 16x5 keyboard matrix.
// PS/2 events are queued in a small FIFO and applied one at a time by a
// small FSM. A key release is held off until a minimum time has passed since
// the last press, so a quick tap is still seen by the CPU's keyboard scan.
//
// Parameters
//   MIN_HOLD  minimum clk_sys cycles a bit stays set after a press
//   FIFO_AW   event FIFO address width (depth = 2**FIFO_AW)
//
// Ports
//   clk_sys       in   system clock
//   reset         in   asynchronous, active-high reset
//   ps2_key[10:0] in   {toggle, pressed, extended, scancode[7:0]}
//   row_sel[3:0]  in   matrix row selected by the CPU
//   col_out[4:0]  out  active-low columns of the selected row (registered)
//   kbd_busy      out  FIFO non-empty or FSM not idle
//   kbd_overflow  out  sticky: an event was dropped on a full FIFO
//   ovf_clr       in   one-cycle pulse clearing kbd_overflow
//
// Optional build macro
//   SORCERER_KBD_NUMPAD_EN  maps the PS/2 keypad digits onto rows 14-15.
//                           Without it those codes are ignored and rows
//                           14-15 always read 5'h1F.
// ---------------------------------------------------------------------------
module sorcerer_kbd_matrix #(
    parameter logic [17:0] MIN_HOLD = 18'd200000,
    parameter int          FIFO_AW  = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [3:0]  row_sel,
    output logic [4:0]  col_out,
    output logic        kbd_busy,
    output logic        kbd_overflow,
    input  logic        ovf_clr
);

    localparam int DEPTH = 2 ** FIFO_AW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        APPLY = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // FIFO entry: {pressed, extended, scancode}
    typedef struct packed {
        logic       pressed;
        logic       ext;
        logic [7:0] code;
    } kev_t;

    state_t                state, state_nxt;
    logic                  tog_ref;
    logic                  evt, push, drop, pop;
    kev_t                  fifo_mem [DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
    logic [FIFO_AW:0]      fifo_cnt;
    logic                  fifo_empty, fifo_full;
    kev_t                  head;

    logic                  km_valid;
    logic [3:0]            km_row;
    logic [2:0]            km_col;

    logic                  ev_valid, ev_pressed;
    logic [3:0]            ev_row;
    logic [2:0]            ev_col;

    logic [15:0][4:0]      matrix;
    logic [17:0]           hold_cnt;
    logic                  hold_zero;
    logic                  mat_set, mat_clr;

    // -----------------------------------------------------------------------
    // Event capture
    // -----------------------------------------------------------------------
    // The toggle reference simply follows ps2_key[10] every cycle, including
    // while reset is high, so the first cycle out of reset sees no edge.
    // Event detection is masked during reset for the same reason.
    always_ff @(posedge clk_sys) begin
        tog_ref <= ps2_key[10];
    end

    assign evt  = ~reset & (ps2_key[10] != tog_ref);
    assign push = evt & ~fifo_full;
    assign drop = evt &  fifo_full;

    // -----------------------------------------------------------------------
    // Event FIFO
    // -----------------------------------------------------------------------
    // Count runs 0..DEPTH, so the MSB alone means full.
    assign fifo_full  = fifo_cnt[FIFO_AW];
    assign fifo_empty = (fifo_cnt == '0);
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge clk_sys) begin
        if (push) fifo_mem[wr_ptr] <= kev_t'(ps2_key[9:0]);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)        kbd_overflow <= 1'b0;
        else if (drop)    kbd_overflow <= 1'b1;   // set beats a same-cycle clear
        else if (ovf_clr) kbd_overflow <= 1'b0;
    end

    // -----------------------------------------------------------------------
    // Keymap: {extended, code} -> {valid, row, col}
    // -----------------------------------------------------------------------
    function automatic logic [7:0] ent(input logic [3:0] r, input logic [2:0] c);
        return {1'b1, r, c};
    endfunction

    always_comb begin
        logic [7:0] km;
        km = 8'h00;
        case ({head.ext, head.code})
            // modifiers and control keys
            9'h012, 9'h059: km = ent(4'd0, 3'd4);   // L/R shift share one bit
            9'h014:         km = ent(4'd0, 3'd2);   // L-ctrl
            9'h076:         km = ent(4'd0, 3'd0);   // Esc
            9'h029:         km = ent(4'd1, 3'd2);   // Space
            9'h05A:         km = ent(4'd6, 3'd3);   // Enter
            // row 2
            9'h022:         km = ent(4'd2, 3'd0);   // X
            9'h01A:         km = ent(4'd2, 3'd1);   // Z
            9'h01D:         km = ent(4'd2, 3'd2);   // W
            9'h015:         km = ent(4'd2, 3'd3);   // Q
            9'h016:         km = ent(4'd2, 3'd4);   // 1
            // row 3
            9'h021:         km = ent(4'd3, 3'd0);   // C
            9'h023:         km = ent(4'd3, 3'd1);   // D
            9'h01B:         km = ent(4'd3, 3'd2);   // S
            9'h024:         km = ent(4'd3, 3'd3);   // E
            9'h01C:         km = ent(4'd3, 3'd4);   // A
            // row 4
            9'h02A:         km = ent(4'd4, 3'd0);   // V
            9'h032:         km = ent(4'd4, 3'd1);   // B
            9'h034:         km = ent(4'd4, 3'd2);   // G
            9'h02C:         km = ent(4'd4, 3'd3);   // T
            9'h02D:         km = ent(4'd4, 3'd4);   // R
            // row 5
            9'h031:         km = ent(4'd5, 3'd0);   // N
            9'h03A:         km = ent(4'd5, 3'd1);   // M
            9'h033:         km = ent(4'd5, 3'd2);   // H
            9'h035:         km = ent(4'd5, 3'd3);   // Y
            9'h02B:         km = ent(4'd5, 3'd4);   // F
            // row 6
            9'h03B:         km = ent(4'd6, 3'd0);   // J
            9'h042:         km = ent(4'd6, 3'd1);   // K
            9'h03C:         km = ent(4'd6, 3'd2);   // U
            9'h043:         km = ent(4'd6, 3'd4);   // I
            // row 7
            9'h04B:         km = ent(4'd7, 3'd0);   // L
            9'h044:         km = ent(4'd7, 3'd1);   // O
            9'h04D:         km = ent(4'd7, 3'd2);   // P
            9'h01E:         km = ent(4'd7, 3'd3);   // 2
            9'h026:         km = ent(4'd7, 3'd4);   // 3
            // rows 8-9: remaining digits
            9'h025:         km = ent(4'd8, 3'd0);   // 4
            9'h02E:         km = ent(4'd8, 3'd1);   // 5
            9'h036:         km = ent(4'd8, 3'd2);   // 6
            9'h03D:         km = ent(4'd8, 3'd3);   // 7
            9'h03E:         km = ent(4'd8, 3'd4);   // 8
            9'h046:         km = ent(4'd9, 3'd0);   // 9
            9'h045:         km = ent(4'd9, 3'd1);   // 0
`ifdef SORCERER_KBD_NUMPAD_EN
            // keypad digits -> numeric pad rows 14-15
            9'h070:         km = ent(4'd14, 3'd0);  // KP 0
            9'h069:         km = ent(4'd14, 3'd1);  // KP 1
            9'h072:         km = ent(4'd14, 3'd2);  // KP 2
            9'h07A:         km = ent(4'd14, 3'd3);  // KP 3
            9'h06B:         km = ent(4'd14, 3'd4);  // KP 4
            9'h073:         km = ent(4'd15, 3'd0);  // KP 5
            9'h074:         km = ent(4'd15, 3'd1);  // KP 6
            9'h06C:         km = ent(4'd15, 3'd2);  // KP 7
            9'h075:         km = ent(4'd15, 3'd3);  // KP 8
            9'h07D:         km = ent(4'd15, 3'd4);  // KP 9
`endif
            default:        km = 8'h00;
        endcase
        km_valid = km[7];
        km_row   = km[6:3];
        km_col   = km[2:0];
    end

    // Registered keymap result for the event being applied. It stays
    // latched through WAIT while a release is deferred.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ev_valid   <= 1'b0;
            ev_pressed <= 1'b0;
            ev_row     <= '0;
            ev_col     <= '0;
        end else if (state == POP) begin
            ev_valid   <= km_valid;
            ev_pressed <= head.pressed;
            ev_row     <= km_row;
            ev_col     <= km_col;
        end
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    assign hold_zero = (hold_cnt == '0);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!fifo_empty) state_nxt = POP;
            POP:   state_nxt = APPLY;
            APPLY: begin
                if (ev_valid && !ev_pressed && !hold_zero) state_nxt = WAIT;
                else                                       state_nxt = IDLE;
            end
            WAIT:  if (hold_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The head is removed from the FIFO as it is decoded in POP; from then on
    // the event lives in the ev_* registers, so a deferred release does not
    // occupy a FIFO slot.
    always_comb begin
        pop     = (state == POP);
        mat_set = (state == APPLY) && ev_valid && ev_pressed;
        mat_clr = ((state == APPLY) && ev_valid && !ev_pressed && hold_zero) ||
                  ((state == WAIT) && hold_zero);
    end

    assign kbd_busy = !fifo_empty || (state != IDLE);

    // -----------------------------------------------------------------------
    // Hold counter and matrix
    // -----------------------------------------------------------------------
    // One global window: every press reloads it, whatever key it was.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)           hold_cnt <= '0;
        else if (mat_set)    hold_cnt <= MIN_HOLD;
        else if (!hold_zero) hold_cnt <= hold_cnt - 1'b1;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)        matrix <= '0;
        else if (mat_set) matrix[ev_row][ev_col] <= 1'b1;
        else if (mat_clr) matrix[ev_row][ev_col] <= 1'b0;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            col_out <= 5'h1F;
        end else begin
`ifdef SORCERER_KBD_NUMPAD_EN
            col_out <= ~matrix[row_sel];
`else
            // numeric pad rows are not populated in this build
            if (row_sel[3:1] == 3'b111) col_out <= 5'h1F;
            else                        col_out <= ~matrix[row_sel];
`endif
        end
    end

endmodule

// File: tb/tb_sorcerer_kbd_matrix.sv
module tb_sorcerer_kbd_matrix;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [10:0] ps2_key = 11'h400;
    logic [3:0]  row_sel = 4'd0;
    logic        ovf_clr = 1'b0;
    logic [4:0]  col_out;
    logic        kbd_busy;
    logic        kbd_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    sorcerer_kbd_matrix #(.MIN_HOLD(18'd100), .FIFO_AW(2)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ps2_key      (ps2_key),
        .row_sel      (row_sel),
        .col_out      (col_out),
        .kbd_busy     (kbd_busy),
        .kbd_overflow (kbd_overflow),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Flip the toggle bit to present one event, then let one edge capture it.
    task automatic send(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        tick();
    endtask

    // Select a row and poll col_out for up to max_cyc cycles.
    task automatic wait_col(input string tag, input logic [3:0] r,
                            input logic [4:0] exp, input int max_cyc);
        row_sel = r;
        tick();
        for (int i = 0; i < max_cyc; i++) begin
            if (col_out === exp) break;
            tick();
        end
        chk(tag, {3'b0, col_out}, {3'b0, exp});
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (kbd_busy === 1'b0) break;
            tick();
        end
        chk(tag, {7'b0, kbd_busy}, 8'h00);
    endtask

    task automatic row_is(input string tag, input logic [3:0] r, input logic [4:0] exp);
        row_sel = r;
        tick();
        chk(tag, {3'b0, col_out}, {3'b0, exp});
    endtask

    initial begin
        // ---- 1: reset with toggle high, then a quiet interface ----
        ticks(3);
        chk("rst_col", {3'b0, col_out}, 8'h1F);
        chk("rst_busy", {7'b0, kbd_busy}, 8'h00);
        reset = 1'b0;
        ticks(100);
        chk("idle_busy", {7'b0, kbd_busy}, 8'h00);
        chk("idle_ovf", {7'b0, kbd_overflow}, 8'h00);
        for (int r = 0; r < 16; r++) row_is("idle_row", 4'(r), 5'h1F);

        // ---- 2: tap 'A' after the hold window ----
        send(1'b1, 1'b0, 8'h1C);
        wait_col("a_press", 4'd3, 5'h0F, 5);
        ticks(110);
        send(1'b0, 1'b0, 8'h1C);
        wait_col("a_release", 4'd3, 5'h1F, 5);

        // ---- 3: short Enter tap, release deferred ----
        send(1'b1, 1'b0, 8'h5A);
        row_sel = 4'd6;
        ticks(10);
        send(1'b0, 1'b0, 8'h5A);
        ticks(60);
        chk("enter_held", {3'b0, col_out}, 8'h17);
        chk("enter_busy", {7'b0, kbd_busy}, 8'h01);
        wait_col("enter_rel", 4'd6, 5'h1F, 60);
        tick();
        chk("enter_idle", {7'b0, kbd_busy}, 8'h00);

        // ---- 4: overflow while FSM waits ----
        send(1'b1, 1'b0, 8'h1C);
        ticks(5);
        send(1'b0, 1'b0, 8'h1C);        // deferred release -> WAIT
        send(1'b1, 1'b0, 8'h29);        // space
        send(1'b1, 1'b0, 8'h76);        // esc
        send(1'b1, 1'b0, 8'h14);        // ctrl
        send(1'b1, 1'b0, 8'h12);        // shift
        send(1'b1, 1'b0, 8'h5A);        // enter: dropped
        chk("ovf_set", {7'b0, kbd_overflow}, 8'h01);
        chk("ovf_busy", {7'b0, kbd_busy}, 8'h01);
        row_is("ovf_space_pending", 4'd1, 5'h1F);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr", {7'b0, kbd_overflow}, 8'h00);
        wait_col("ovf_a_rel", 4'd3, 5'h1F, 120);
        wait_idle("ovf_drain", 60);
        row_is("ovf_row1", 4'd1, 5'h1B);
        row_is("ovf_row0", 4'd0, 5'h0A);
        row_is("ovf_dropped", 4'd6, 5'h1F);

        // ---- 5: both shifts share one bit ----
        send(1'b0, 1'b0, 8'h76);
        send(1'b0, 1'b0, 8'h14);
        wait_idle("rel_drain", 250);
        row_is("shift_only", 4'd0, 5'h0F);
        send(1'b1, 1'b0, 8'h59);
        ticks(120);
        row_is("shift_both", 4'd0, 5'h0F);
        send(1'b0, 1'b0, 8'h12);
        wait_col("shift_rel", 4'd0, 5'h1F, 8);

        // ---- 6: extended/unmapped, numpad, set-wins, reset in WAIT ----
        send(1'b1, 1'b1, 8'h5A);        // extended Enter: not mapped
        wait_idle("ext_idle", 10);
        row_is("ext_nochg", 4'd6, 5'h1F);
        send(1'b1, 1'b0, 8'h69);
        wait_idle("kp_idle", 10);
`ifdef SORCERER_KBD_NUMPAD_EN
        row_is("kp1", 4'd14, 5'h1D);
`else
        row_is("kp1", 4'd14, 5'h1F);
`endif
        send(1'b1, 1'b0, 8'h1C);
        ticks(3);
        send(1'b0, 1'b0, 8'h1C);
        ticks(3);
        chk("wait_busy", {7'b0, kbd_busy}, 8'h01);
        send(1'b1, 1'b0, 8'h0F);
        send(1'b0, 1'b0, 8'h0F);
        send(1'b1, 1'b0, 8'h0F);
        send(1'b0, 1'b0, 8'h0F);
        ovf_clr = 1'b1;
        send(1'b1, 1'b0, 8'h0F);        // dropped in the same cycle as ovf_clr
        ovf_clr = 1'b0;
        chk("ovf_set_wins", {7'b0, kbd_overflow}, 8'h01);
        reset = 1'b1;
        #1;
        chk("arst_busy", {7'b0, kbd_busy}, 8'h00);
        chk("arst_ovf", {7'b0, kbd_overflow}, 8'h00);
        chk("arst_col", {3'b0, col_out}, 8'h1F);
        ps2_key = {~ps2_key[10], 10'h000};   // toggle during reset: tracked
        ticks(2);
        reset = 1'b0;
        ticks(5);
        chk("post_rst_busy", {7'b0, kbd_busy}, 8'h00);
        row_is("post_rst_row3", 4'd3, 5'h1F);
        row_is("post_rst_row1", 4'd1, 5'h1F);
        row_is("post_rst_row14", 4'd14, 5'h1F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
